// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter slice.
// The PARITY state is only entered when UART_TX_PARITY_EN is defined.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam int DEFAULT_CLKS_PER_BIT = 32'd5208;
    localparam int UART_DATA_BITS       = 32'd8;

    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period tick generator: counts 0..CLKS_PER_BIT-1 and pulses tick on the
// last count; clear holds the count at zero.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic nRST,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 32'd1) ? $clog2(CLKS_PER_BIT) : 32'd1;
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(CLKS_PER_BIT - 32'd1);

    logic [CNT_W-1:0] count_r;

    assign tick = (count_r == LAST_COUNT);

    // Bit-period counter, wraps after the tick cycle.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            count_r <= '0;
        end else if (clear || tick) begin
            count_r <= '0;
        end else begin
            count_r <= count_r + CNT_W'(1'b1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 serial transmitter with valid/ready byte input and registered line output.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = UART_DATA_BITS
) (
    input  logic       clk,
    input  logic       nRST,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 32'd1);

    tx_state_t  state_r, state_next_s;
    logic [7:0] shift_r, shift_next_s;
    logic [2:0] bit_idx_r, bit_idx_next_s;
    logic       tx_r, tx_next_s;
    logic       tick_s;
    logic       clear_s;
`ifdef UART_TX_PARITY_EN
    logic       parity_r;
`endif

    assign clear_s  = (state_r == IDLE);
    assign tx_ready = (state_r == IDLE);
    assign busy     = (state_r != IDLE);
    assign tx       = tx_r;

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick (
        .clk   (clk),
        .nRST  (nRST),
        .clear (clear_s),
        .tick  (tick_s)
    );

    // Frame sequencing: next state, shift register and bit index.
    always_comb begin
        state_next_s   = state_r;
        shift_next_s   = shift_r;
        bit_idx_next_s = bit_idx_r;
        case (state_r)
            IDLE: begin
                if (tx_valid) begin
                    state_next_s   = START;
                    shift_next_s   = tx_data;
                    bit_idx_next_s = 3'd0;
                end else begin
                    state_next_s = IDLE;
                end
            end
            START: begin
                if (tick_s) begin
                    state_next_s = DATA;
                end else begin
                    state_next_s = START;
                end
            end
            DATA: begin
                if (tick_s) begin
                    shift_next_s   = {1'b0, shift_r[7:1]};
                    bit_idx_next_s = bit_idx_r + 3'd1;
                    if (bit_idx_r == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_next_s = PARITY;
`else
                        state_next_s = STOP;
`endif
                    end else begin
                        state_next_s = DATA;
                    end
                end else begin
                    state_next_s = DATA;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick_s) begin
                    state_next_s = STOP;
                end else begin
                    state_next_s = PARITY;
                end
            end
`endif
            STOP: begin
                if (tick_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = STOP;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Line level decoded from the upcoming state so tx is a clean register.
    always_comb begin
        tx_next_s = 1'b1;
        case (state_next_s)
            IDLE:    tx_next_s = 1'b1;
            START:   tx_next_s = 1'b0;
            DATA:    tx_next_s = shift_next_s[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_next_s = parity_r;
`endif
            STOP:    tx_next_s = 1'b1;
            default: tx_next_s = 1'b1;
        endcase
    end

    // State, datapath and output registers; reset drives the line idle high.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_r   <= IDLE;
            shift_r   <= 8'd0;
            bit_idx_r <= 3'd0;
            tx_r      <= 1'b1;
        end else begin
            state_r   <= state_next_s;
            shift_r   <= shift_next_s;
            bit_idx_r <= bit_idx_next_s;
            tx_r      <= tx_next_s;
        end
    end

`ifdef UART_TX_PARITY_EN
    // Parity captured at accept, before the shift register consumes the byte.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            parity_r <= 1'b0;
        end else if ((state_r == IDLE) && tx_valid) begin
            parity_r <= even_parity(tx_data);
        end else begin
            parity_r <= parity_r;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: two instances (4 and 2 clocks per bit)
// compared cycle by cycle against a frame-slot model of the serial line.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic       clk = 1'b0;
    logic       nrst;
    logic       sel;
    logic       valid_a, valid_b;
    logic [7:0] data_a, data_b;
    logic       ready_a, ready_b, tx_a, tx_b, busy_a, busy_b;
    logic       obs_tx, obs_ready, obs_busy;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;

    uart_tx #(.CLKS_PER_BIT(4)) dut_a (
        .clk(clk), .nRST(nrst), .tx_valid(valid_a), .tx_data(data_a),
        .tx_ready(ready_a), .tx(tx_a), .busy(busy_a)
    );

    uart_tx #(.CLKS_PER_BIT(2)) dut_b (
        .clk(clk), .nRST(nrst), .tx_valid(valid_b), .tx_data(data_b),
        .tx_ready(ready_b), .tx(tx_b), .busy(busy_b)
    );

    assign obs_tx    = sel ? tx_b    : tx_a;
    assign obs_ready = sel ? ready_b : ready_a;
    assign obs_busy  = sel ? busy_b  : busy_a;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int cpb();
        return sel ? 2 : 4;
    endfunction

    // Level the line must carry during frame slot 'slot' for byte b.
    function automatic logic expected_line(logic [7:0] b, int slot);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        if (slot == 0) return 1'b0;
        if (slot <= 8) return b[slot-1];
`ifdef UART_TX_PARITY_EN
        if (slot == 9) return (ones % 2) == 1;
`endif
        return 1'b1;
    endfunction

    task automatic chk_bit(string tag, logic obs, logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(string tag, int obs, int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(logic v, logic [7:0] d);
        if (sel) begin
            valid_b = v; data_b = d;
        end else begin
            valid_a = v; data_a = d;
        end
    endtask

    task automatic check_quiet(string tag, int n);
        logic bad = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (obs_tx !== 1'b1 || obs_ready !== 1'b1 || obs_busy !== 1'b0) bad = 1'b1;
        end
        chk_bit(tag, bad, 1'b0);
    endtask

    // Send one byte and check every cycle of the frame against the slot model.
    task automatic send_frame(logic [7:0] b, logic hold, logic [7:0] next_b,
                              logic mutate, output int acc_cyc);
        logic ok = 1'b0;
        int   c = cpb();
        for (int i = 0; i < 200; i++) begin
            if (obs_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk_bit("ready_wait", ok, 1'b1);
        drive(1'b1, b);
        @(posedge clk);
        @(negedge clk);
        acc_cyc = cyc;
        if (hold) drive(1'b1, next_b);
        else      drive(1'b0, b);
        for (int t = 0; t < NBITS * c; t++) begin
            if (t > 0) @(negedge clk);
            chk_bit($sformatf("tx_slot%0d_t%0d", t / c, t), obs_tx, expected_line(b, t / c));
            chk_bit($sformatf("ready_low_t%0d", t), obs_ready, 1'b0);
            chk_bit($sformatf("busy_t%0d", t), obs_busy, 1'b1);
            if (mutate) begin
                if (t == 1)         drive(1'b0, ~b);
                if (t == 3 * c)     drive(1'b1, ~b);
                if (t == 3 * c + 1) drive(1'b0, ~b);
            end
        end
        @(negedge clk);
        chk_bit("end_ready", obs_ready, 1'b1);
        chk_bit("end_tx_idle", obs_tx, 1'b1);
    endtask

    initial begin
        int          acc0, acc1;
        logic [7:0]  rb;
        nrst = 1'b0; sel = 1'b0;
        valid_a = 1'b0; valid_b = 1'b0; data_a = 8'h00; data_b = 8'h00;
        repeat (2) @(negedge clk);
        chk_bit("rst_tx_a", tx_a, 1'b1);
        chk_bit("rst_ready_a", ready_a, 1'b1);
        chk_bit("rst_busy_a", busy_a, 1'b0);
        chk_bit("rst_tx_b", tx_b, 1'b1);
        nrst = 1'b1;
        check_quiet("idle_after_reset", 5);

        // Single byte 0xA5.
        send_frame(8'hA5, 1'b0, 8'h00, 1'b0, acc0);
        check_quiet("idle_after_a5", 3);

        // Back-to-back 0x00 then 0xFF with valid held.
        send_frame(8'h00, 1'b1, 8'hFF, 1'b0, acc0);
        send_frame(8'hFF, 1'b0, 8'h00, 1'b0, acc1);
        chk_int("b2b_accept_gap", acc1 - acc0, NBITS * 4 + 1);
        check_quiet("idle_after_b2b", 3);

        // Data change during START and valid pulse mid-frame are ignored.
        send_frame(8'h3C, 1'b0, 8'h00, 1'b1, acc0);
        check_quiet("no_second_accept", 20);

        // Minimum bit period.
        sel = 1'b1;
        send_frame(8'h01, 1'b0, 8'h00, 1'b0, acc0);
        check_quiet("idle_after_cpb2", 3);

        // Parity-sensitive bytes.
        sel = 1'b0;
        send_frame(8'h07, 1'b0, 8'h00, 1'b0, acc0);
        send_frame(8'h03, 1'b0, 8'h00, 1'b0, acc0);

        // Random bytes on either instance.
        for (int k = 0; k < 8; k++) begin
            sel = 1'($urandom_range(0, 1));
            rb  = 8'($urandom);
            send_frame(rb, 1'b0, 8'h00, 1'b0, acc0);
        end

        // Reset mid-DATA on dut_a (dut_b idle at the same moment).
        sel = 1'b0;
        @(negedge clk);
        drive(1'b1, 8'h00);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 8'h00);
        repeat (9) @(negedge clk);
        chk_bit("pre_reset_busy", busy_a, 1'b1);
        #2 nrst = 1'b0;
        #1;
        chk_bit("mid_data_rst_tx", tx_a, 1'b1);
        chk_bit("mid_data_rst_ready", ready_a, 1'b1);
        chk_bit("mid_data_rst_busy", busy_a, 1'b0);
        chk_bit("mid_idle_rst_tx", tx_b, 1'b1);
        chk_bit("mid_idle_rst_ready", ready_b, 1'b1);
        chk_bit("mid_idle_rst_busy", busy_b, 1'b0);
        @(negedge clk);
        nrst = 1'b1;
        check_quiet("no_resend_a", 60);
        sel = 1'b1;
        check_quiet("no_frame_b", 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
